drop_bay_sequencer: RTL

- Multi-bay successor to the single-bay temperature-gated baggage-drop controller.
- Monitors NUM_BAYS bays, each with its own enable, actual temperature and limit.
- Grants the shared drop chute to one eligible bay at a time (round-robin) and holds the drop for a timed pulse, then a cooldown gap.
- Drives four 7-segment digits with the status of an operator-selected bay. Sits between the bay sensor front-end and the chute actuator/display board.

---
 rtl/drop_pkg.sv | 52 +++++
 rtl/drop_bay_sequencer_if.sv | 31 +++
 rtl/drop_rr_arbiter.sv | 35 +++
 rtl/drop_bay_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared definitions for the multi-bay drop sequencer: 7-segment glyphs,
// FSM state encoding, display message codes and small helpers.
package drop_pkg;

  // Segment glyphs, bit order gfedcba, active-high
  localparam logic [6:0] SEG_d     = 7'b1011110;
  localparam logic [6:0] SEG_r     = 7'b1010000;
  localparam logic [6:0] SEG_o     = 7'b1011100;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_H     = 7'b1110110;
  localparam logic [6:0] SEG_t     = 7'b1111000;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_n     = 7'b1010100;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MSG_BLANK = 3'd0,
    MSG_DROP  = 3'd1,
    MSG_COLD  = 3'd2,
    MSG_HOT   = 3'd3,
    MSG_DONE  = 3'd4,
    MSG_PEND  = 3'd5
  } msg_t;

  // Width of a bay index; a single-bay build still gets a 1-bit selector.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Four digits packed left to right: {seg1, seg2, seg3, seg4}
  function automatic logic [27:0] msg_digits(input msg_t m);
    logic [27:0] d;
    case (m)
      MSG_DROP: d = {SEG_d, SEG_r, SEG_o, SEG_P};
      MSG_COLD: d = {SEG_C, SEG_o, SEG_L, SEG_d};
      MSG_HOT:  d = {SEG_BLANK, SEG_H, SEG_o, SEG_t};
      MSG_DONE: d = {SEG_d, SEG_o, SEG_n, SEG_E};
      MSG_PEND: d = {SEG_P, SEG_E, SEG_n, SEG_d};
      default:  d = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/drop_bay_sequencer_if.sv
// Bay sensor / chute actuator / display bundle for drop_bay_sequencer.
// master: sensor front-end side driving requests and temperatures.
// slave:  the sequencer.
interface drop_bay_sequencer_if #(
  parameter int NUM_BAYS = 4,
  parameter int TW       = 16
);
  localparam int SELW = drop_pkg::sel_width(NUM_BAYS);

  logic [NUM_BAYS-1:0]    drop_en;
  logic [NUM_BAYS*TW-1:0] t_act;
  logic [NUM_BAYS*TW-1:0] t_lim;
  logic [SELW-1:0]        disp_sel;
  logic [6:0]             seven_seg1;
  logic [6:0]             seven_seg2;
  logic [6:0]             seven_seg3;
  logic [6:0]             seven_seg4;
  logic [NUM_BAYS-1:0]    drop_activated;
  logic                   busy;

  modport master (
    output drop_en, t_act, t_lim, disp_sel,
    input  seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy
  );

  modport slave (
    input  drop_en, t_act, t_lim, disp_sel,
    output seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy
  );

endinterface

// File: rtl/drop_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest-index request at or
// after ptr, wrapping past the top bay.
module drop_rr_arbiter
  import drop_pkg::*;
#(
  parameter int NUM_BAYS = 4,
  parameter int SELW     = sel_width(NUM_BAYS)
) (
  input  logic [NUM_BAYS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [NUM_BAYS-1:0] grant,
  output logic [SELW-1:0]     grant_idx,
  output logic                grant_vld
);

  // Walk the bays starting at ptr; the first request seen wins.
  always_comb begin
    int j;
    logic [SELW-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_BAYS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_BAYS) j = j - NUM_BAYS;
      jj = j[SELW-1:0];
      if (!grant_vld && req[jj]) begin
        grant[jj] = 1'b1;
        grant_idx = jj;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drop_bay_sequencer.sv
// Multi-bay temperature-gated drop sequencer. Grants the shared chute to one
// cool, enabled, not-yet-served bay at a time, holds the drop for DROP_CYCLES,
// then idles GAP_CYCLES before the next grant. Shows one bay's status on four
// 7-segment digits.
// Optional build macro: HYSTERESIS_EN (registered per-bay hot flag with HYST
// margin on the way back down).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | chute free; grant next ready bay round-robin
// ST_DROP | drop_activated held for the granted bay, counting down
// ST_GAP  | chute resting between drops, counting down
module drop_bay_sequencer
  import drop_pkg::*;
#(
  parameter int NUM_BAYS    = 4,
  parameter int TW          = 16,
  parameter int DROP_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int HYST        = 2
) (
  input logic               clk,
  input logic               rst,
  drop_bay_sequencer_if.slave bus
);

  localparam int SELW    = sel_width(NUM_BAYS);
  localparam int CNT_MAX = (DROP_CYCLES > GAP_CYCLES) ? DROP_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (NUM_BAYS < 1 || NUM_BAYS > 16 || DROP_CYCLES < 1 || GAP_CYCLES < 0 || HYST < 0)
  begin : g_param_err
    $error("drop_bay_sequencer: parameter out of range");
  end

  logic [NUM_BAYS-1:0] hot;
  logic [NUM_BAYS-1:0] ready;
  logic [NUM_BAYS-1:0] served_q, served_d;
  logic [NUM_BAYS-1:0] drop_act_q, drop_act_d;
  logic [NUM_BAYS-1:0] arb_grant;
  logic [SELW-1:0]     arb_idx;
  logic                arb_vld;
  logic [SELW-1:0]     rr_q, rr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic                grant_en;
  logic                busy_q;
  msg_t                msg_d;
  logic [27:0]         seg_q;

`ifdef HYSTERESIS_EN
  localparam logic [TW:0] HYST_W = (TW+1)'(HYST);
  logic [NUM_BAYS-1:0] hot_q;

  // Hot flag sets above the limit and only clears once HYST below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hot_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BAYS; i++) begin
        if (bus.t_act[i*TW +: TW] > bus.t_lim[i*TW +: TW])
          hot_q[i] <= 1'b1;
        else if (({1'b0, bus.t_act[i*TW +: TW]} + HYST_W) <= {1'b0, bus.t_lim[i*TW +: TW]})
          hot_q[i] <= 1'b0;
      end
    end
  end

  assign hot = hot_q;
`else
  // Plain over-limit compare per bay.
  always_comb begin
    hot = '0;
    for (int i = 0; i < NUM_BAYS; i++)
      hot[i] = bus.t_act[i*TW +: TW] > bus.t_lim[i*TW +: TW];
  end
`endif

  assign ready = bus.drop_en & ~hot & ~served_q;

  drop_rr_arbiter #(
    .NUM_BAYS (NUM_BAYS),
    .SELW     (SELW)
  ) u_arb (
    .req       (ready),
    .ptr       (rr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Next-state, counter, pointer and chute-drive logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    drop_act_d = drop_act_q;
    grant_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d    = ST_DROP;
          cnt_d      = CW'(DROP_CYCLES - 1);
          drop_act_d = arb_grant;
          grant_en   = 1'b1;
          rr_d       = (arb_idx == SELW'(NUM_BAYS - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_DROP: begin
        // Committed: request/temperature changes do not cut the pulse short.
        if (cnt_q == '0) begin
          drop_act_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        drop_act_d = '0;
      end
    endcase
    // One drop per enable assertion: served only clears while drop_en is low.
    served_d = (served_q | (grant_en ? arb_grant : '0)) & bus.drop_en;
  end

  // Status message for the selected bay; out-of-range selectors go blank.
  always_comb begin
    msg_d = MSG_BLANK;
    if (int'(bus.disp_sel) < NUM_BAYS) begin
      if (state_q == ST_DROP && drop_act_q[bus.disp_sel]) msg_d = MSG_DROP;
      else if (!bus.drop_en[bus.disp_sel])                msg_d = MSG_COLD;
      else if (hot[bus.disp_sel])                         msg_d = MSG_HOT;
      else if (served_q[bus.disp_sel])                    msg_d = MSG_DONE;
      else                                                msg_d = MSG_PEND;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rr_q       <= '0;
      served_q   <= '0;
      drop_act_q <= '0;
      busy_q     <= 1'b0;
      seg_q      <= msg_digits(MSG_COLD);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      served_q   <= served_d;
      drop_act_q <= drop_act_d;
      busy_q     <= (state_d != ST_IDLE);
      seg_q      <= msg_digits(msg_d);
    end
  end

  assign bus.drop_activated = drop_act_q;
  assign bus.busy           = busy_q;
  assign bus.seven_seg1     = seg_q[27:21];
  assign bus.seven_seg2     = seg_q[20:14];
  assign bus.seven_seg3     = seg_q[13:7];
  assign bus.seven_seg4     = seg_q[6:0];

endmodule
